mode_mux_n: RTL and testbench
=============================

MODE_MUX_N -- requirements
Module: mode_mux_n

Interface
REQ-001 Parameter NUM_SRC, default 3, number of player-2 control sources (keyboard, AI, replay); range 2..8.
REQ-002 Parameter ACT_W, default 8, action bits per source (right, left, stand, kick, fight, jump, dodge, back; bit 0 = right).
REQ-003 Parameter POS_W, default 10, width of each X/Y position.
REQ-004 SEL_W = $clog2(NUM_SRC), derived, not overridable.
REQ-005 Port Clk  input  1  system clock; single clock domain.
REQ-006 Port Reset_n  input  1  asynchronous active-low reset.
REQ-007 Port VGA_VS  input  1  vertical sync, asynchronous to Clk.
REQ-008 Port mode_en  input  1  1 = a source is requested; 0 = none.
REQ-009 Port mode_sel  input  SEL_W  requested source index.
REQ-010 Port game_over  input  1  round ended (p1win OR p2win).
REQ-011 Port src_act  input  NUM_SRC*ACT_W  action bits; source i at [i*ACT_W +: ACT_W].
REQ-012 Port src_x, src_y  input  NUM_SRC*POS_W each  positions; source i at [i*POS_W +: POS_W].
REQ-013 Port act_out  output  ACT_W  registered selected actions.
REQ-014 Port x_out, y_out  output  POS_W each  registered selected position.
REQ-015 Port active_src  output  SEL_W  index currently owning the outputs.
REQ-016 Port switching  output  1  high while in BLANK.

Function
REQ-017 VGA_VS passes a 2-flop synchronizer; frame_tick is a one-Clk pulse on the synchronized rising edge.
REQ-018 Request valid = mode_en AND mode_sel < NUM_SRC; out-of-range mode_sel is treated as mode_en = 0.
REQ-019 States: IDLE, ACTIVE, BLANK, FROZEN; transitions occur only on frame_tick cycles.
REQ-020 Priority at frame_tick: game_over, then invalid request, then source change.
REQ-021 Any state, game_over = 1 at frame_tick -> FROZEN; FROZEN, game_over = 0 at frame_tick -> IDLE.
REQ-022 IDLE, valid request -> BLANK (macro defined) or ACTIVE (macro undefined); active_src <= mode_sel.
REQ-023 ACTIVE, invalid -> IDLE; valid with mode_sel != active_src -> BLANK/ACTIVE per REQ-022 with new active_src; same index -> stay.
REQ-024 BLANK, invalid -> IDLE; valid with different index -> stay BLANK, reload active_src, restart blank frame; same index -> ACTIVE.
REQ-025 IDLE: act_out, x_out, y_out = 0 from the cycle after entry.
REQ-026 ACTIVE: outputs <= source[active_src] every Clk; one-cycle latency from src_* to outputs.
REQ-027 BLANK: act_out = 0; x_out/y_out track source[active_src] with one-cycle latency.
REQ-028 FROZEN: all outputs and active_src hold values from the cycle before entry.
REQ-029 active_src changes only on a frame_tick cycle; outputs use the new index from the following cycle.
REQ-030 Source inputs change freely between ticks; no handshake; no width truncation anywhere.

Reset
REQ-031 Reset_n low asynchronously forces state IDLE, act_out = 0, x_out = 0, y_out = 0, active_src = 0, switching = 0, synchronizer flops = 0.
REQ-032 Reset mid-BLANK or mid-FROZEN aborts immediately; first transition after release needs a new frame_tick.
REQ-033 Synchronizer reset value 0 means VGA_VS high at release yields one frame_tick two cycles after release.

Configuration
REQ-034 Macro MODE_MUX_BLANK_EN defined: every source entry/change passes through one full BLANK frame (actions zeroed).
REQ-035 MODE_MUX_BLANK_EN undefined: BLANK unreachable, switching tied 0, changes go directly to ACTIVE.

Verification
REQ-036 Reset, mode_en=1, mode_sel=1, src_act[1]=8'h10, 3 ticks, macro on -> frame 1 act_out=0, switching=1; frame 2 act_out=8'h10, active_src=1.
REQ-037 ACTIVE src 0, mode_sel 0->2 mid-frame -> active_src stays 0 until next tick, then 2; macro off -> act_out=src_act[2] one cycle after tick.
REQ-038 mode_sel=3 with NUM_SRC=3, mode_en=1, tick -> IDLE, all outputs 0.
REQ-039 ACTIVE, x_out=10'd320, game_over=1 at tick, src_x changed to 10'd5 -> x_out stays 320; game_over=0 at next tick -> IDLE, x_out=0.
REQ-040 In BLANK, mode_sel 1->2 before next tick -> stays BLANK one more frame, active_src=2, act_out=0.
REQ-041 Reset_n low during BLANK -> same-cycle act_out/x_out/y_out=0, active_src=0, switching=0.

Source files
------------

// File: rtl/mode_mux_n.sv
// mode_mux_n: selects which player-2 control source drives the action and
// position outputs, switching sources only on synchronized VGA frame ticks.
// Optional feature macro: MODE_MUX_BLANK_EN -- when defined, every source entry
// or change passes through one full BLANK frame with the actions zeroed.
module mode_mux_n #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned ACT_W   = 8,
  parameter int unsigned POS_W   = 10,
  localparam int unsigned SEL_W  = $clog2(NUM_SRC)
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     VGA_VS,
  input  logic                     mode_en,
  input  logic [SEL_W-1:0]         mode_sel,
  input  logic                     game_over,
  input  logic [NUM_SRC*ACT_W-1:0] src_act,
  input  logic [NUM_SRC*POS_W-1:0] src_x,
  input  logic [NUM_SRC*POS_W-1:0] src_y,
  output logic [ACT_W-1:0]         act_out,
  output logic [POS_W-1:0]         x_out,
  output logic [POS_W-1:0]         y_out,
  output logic [SEL_W-1:0]         active_src,
  output logic                     switching
);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK, FROZEN} state_t;

`ifdef MODE_MUX_BLANK_EN
  localparam bit ENTRY_BLANK = 1'b1;
`else
  localparam bit ENTRY_BLANK = 1'b0;
`endif
  // State taken whenever a new source is granted.
  localparam state_t ENTRY = ENTRY_BLANK ? BLANK : ACTIVE;

  state_t state;

  logic vs_meta;
  logic vs_sync;
  logic vs_prev;
  logic frame_tick;
  logic req_valid;

  logic [ACT_W-1:0] req_act;
  logic [POS_W-1:0] req_x;
  logic [POS_W-1:0] req_y;
  logic [ACT_W-1:0] cur_act;
  logic [POS_W-1:0] cur_x;
  logic [POS_W-1:0] cur_y;

  // Two-flop synchronizer on VGA_VS plus an edge-detect stage.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= VGA_VS;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign frame_tick = vs_sync & ~vs_prev;

  // Out-of-range selects behave exactly like no request.
  assign req_valid = mode_en && ({1'b0, mode_sel} < (SEL_W + 1)'(NUM_SRC));

  // Source muxes: one for the requested index, one for the current owner.
  always_comb begin
    req_act = '0;
    req_x   = '0;
    req_y   = '0;
    cur_act = '0;
    cur_x   = '0;
    cur_y   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode_sel == SEL_W'(i)) begin
        req_act = src_act[i*ACT_W +: ACT_W];
        req_x   = src_x[i*POS_W +: POS_W];
        req_y   = src_y[i*POS_W +: POS_W];
      end
      if (active_src == SEL_W'(i)) begin
        cur_act = src_act[i*ACT_W +: ACT_W];
        cur_x   = src_x[i*POS_W +: POS_W];
        cur_y   = src_y[i*POS_W +: POS_W];
      end
    end
  end

  // Mode FSM with registered outputs; outputs follow the state being entered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      act_out    <= '0;
      x_out      <= '0;
      y_out      <= '0;
      active_src <= '0;
      switching  <= 1'b0;
    end else if (frame_tick && game_over) begin
      // Freeze: outputs and owner keep their current values.
      state     <= FROZEN;
      switching <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_tick && req_valid) begin
            state      <= ENTRY;
            active_src <= mode_sel;
            switching  <= ENTRY_BLANK;
            act_out    <= ENTRY_BLANK ? '0 : req_act;
            x_out      <= req_x;
            y_out      <= req_y;
          end else begin
            act_out <= '0;
            x_out   <= '0;
            y_out   <= '0;
          end
        end
        ACTIVE: begin
          if (frame_tick && !req_valid) begin
            state   <= IDLE;
            act_out <= '0;
            x_out   <= '0;
            y_out   <= '0;
          end else if (frame_tick && (mode_sel != active_src)) begin
            state      <= ENTRY;
            active_src <= mode_sel;
            switching  <= ENTRY_BLANK;
            act_out    <= ENTRY_BLANK ? '0 : req_act;
            x_out      <= req_x;
            y_out      <= req_y;
          end else begin
            act_out <= cur_act;
            x_out   <= cur_x;
            y_out   <= cur_y;
          end
        end
        BLANK: begin
          if (frame_tick && !req_valid) begin
            state     <= IDLE;
            switching <= 1'b0;
            act_out   <= '0;
            x_out     <= '0;
            y_out     <= '0;
          end else if (frame_tick && (mode_sel != active_src)) begin
            // New request during the blank frame restarts the blank frame.
            active_src <= mode_sel;
            act_out    <= '0;
            x_out      <= req_x;
            y_out      <= req_y;
          end else if (frame_tick) begin
            state     <= ACTIVE;
            switching <= 1'b0;
            act_out   <= cur_act;
            x_out     <= cur_x;
            y_out     <= cur_y;
          end else begin
            act_out <= '0;
            x_out   <= cur_x;
            y_out   <= cur_y;
          end
        end
        FROZEN: begin
          if (frame_tick) begin
            state   <= IDLE;
            act_out <= '0;
            x_out   <= '0;
            y_out   <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mode_mux_n.sv
// tb_mode_mux_n: directed literal checks plus randomized traffic compared every
// cycle against a frame-level behavioural model of the source selector.
module tb_mode_mux_n;

  localparam int NUM_SRC = 3;
  localparam int ACT_W   = 8;
  localparam int POS_W   = 10;
  localparam int SEL_W   = $clog2(NUM_SRC);
  localparam int AW      = NUM_SRC * ACT_W;
  localparam int PW      = NUM_SRC * POS_W;

`ifdef MODE_MUX_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam int M_IDL = 0;
  localparam int M_ACT = 1;
  localparam int M_BLK = 2;
  localparam int M_FRZ = 3;

  logic             Clk;
  logic             Reset_n;
  logic             VGA_VS;
  logic             mode_en;
  logic [SEL_W-1:0] mode_sel;
  logic             game_over;
  logic [AW-1:0]    src_act;
  logic [PW-1:0]    src_x;
  logic [PW-1:0]    src_y;
  logic [ACT_W-1:0] act_out;
  logic [POS_W-1:0] x_out;
  logic [POS_W-1:0] y_out;
  logic [SEL_W-1:0] active_src;
  logic             switching;

  int checks   = 0;
  int failures = 0;

  mode_mux_n #(.NUM_SRC(NUM_SRC), .ACT_W(ACT_W), .POS_W(POS_W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .VGA_VS    (VGA_VS),
    .mode_en   (mode_en),
    .mode_sel  (mode_sel),
    .game_over (game_over),
    .src_act   (src_act),
    .src_x     (src_x),
    .src_y     (src_y),
    .act_out   (act_out),
    .x_out     (x_out),
    .y_out     (y_out),
    .active_src(active_src),
    .switching (switching)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Frame-level model: mode, owner, the shown outputs, and the last three VS samples.
  typedef struct {
    int               mode;
    int               owner;
    logic [ACT_W-1:0] act;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic             p1;
    logic             p2;
    logic             p3;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.mode = M_IDL; r.owner = 0; r.act = '0; r.x = '0; r.y = '0;
    r.p1 = 1'b0; r.p2 = 1'b0; r.p3 = 1'b0;
    return r;
  endfunction

  // A frame tick is seen two samples after VS goes high; decisions happen only then.
  function automatic model_t model_step(model_t c, logic vs, logic en, logic [SEL_W-1:0] sel,
                                        logic go, logic [AW-1:0] a, logic [PW-1:0] xs,
                                        logic [PW-1:0] ys);
    model_t n = c;
    bit tick  = c.p2 && !c.p3;
    bit valid = en && (int'(sel) < NUM_SRC);
    n.p3 = c.p2; n.p2 = c.p1; n.p1 = vs;
    if (tick) begin
      if (go) n.mode = M_FRZ;
      else if (c.mode == M_FRZ || !valid) n.mode = M_IDL;
      else if (c.mode == M_IDL || int'(sel) != c.owner) begin
        n.owner = int'(sel);
        n.mode  = BLANK_EN ? M_BLK : M_ACT;
      end else if (c.mode == M_BLK) n.mode = M_ACT;
    end
    case (n.mode)
      M_IDL: begin n.act = '0; n.x = '0; n.y = '0; end
      M_ACT: begin
        n.act = a[n.owner*ACT_W +: ACT_W];
        n.x   = xs[n.owner*POS_W +: POS_W];
        n.y   = ys[n.owner*POS_W +: POS_W];
      end
      M_BLK: begin
        n.act = '0;
        n.x   = xs[n.owner*POS_W +: POS_W];
        n.y   = ys[n.owner*POS_W +: POS_W];
      end
      default: ;
    endcase
    return n;
  endfunction

  // Advance the model on every clock edge, reset asynchronously like the DUT.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) m <= model_reset();
    else m <= model_step(m, VGA_VS, mode_en, mode_sel, game_over, src_act, src_x, src_y);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge Clk) begin
    if (Reset_n) begin
      chk("m_act_out", 32'(act_out), 32'(m.act));
      chk("m_x_out", 32'(x_out), 32'(m.x));
      chk("m_y_out", 32'(y_out), 32'(m.y));
      chk("m_active_src", 32'(active_src), 32'(m.owner));
      chk("m_switching", 32'(switching), 32'(m.mode == M_BLK));
    end
  end

  // Raise VS and return right after the edge that consumes the tick.
  task automatic tick_rise();
    VGA_VS = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  task automatic tick_fall();
    VGA_VS = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic full_tick();
    tick_rise();
    tick_fall();
  endtask

  int vs_cnt;

  initial begin
    Reset_n = 1'b0; VGA_VS = 1'b0; mode_en = 1'b0; mode_sel = '0; game_over = 1'b0;
    src_act = '0; src_x = '0; src_y = '0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    chk("rst_act", 32'(act_out), 32'h0);
    chk("rst_x", 32'(x_out), 32'h0);
    chk("rst_y", 32'(y_out), 32'h0);
    chk("rst_src", 32'(active_src), 32'h0);
    chk("rst_sw", 32'(switching), 32'h0);

    // First grant of source 1.
    src_act = {8'h33, 8'h10, 8'h01};
    src_x   = {10'd30, 10'd20, 10'd10};
    src_y   = {10'd300, 10'd200, 10'd100};
    mode_en = 1'b1; mode_sel = SEL_W'(1);
    tick_rise();
    chk("f1_src", 32'(active_src), 32'h1);
    chk("f1_x", 32'(x_out), 32'd20);
    chk("f1_act", 32'(act_out), BLANK_EN ? 32'h0 : 32'h10);
    chk("f1_sw", 32'(switching), BLANK_EN ? 32'h1 : 32'h0);
    tick_fall();
    tick_rise();
    chk("f2_act", 32'(act_out), 32'h10);
    chk("f2_src", 32'(active_src), 32'h1);
    chk("f2_sw", 32'(switching), 32'h0);
    tick_fall();

    // Move to source 0, then request 2 mid-frame.
    mode_sel = SEL_W'(0);
    full_tick();
    if (BLANK_EN) full_tick();
    chk("s0_act", 32'(act_out), 32'h01);
    @(negedge Clk);
    mode_sel = SEL_W'(2);
    @(negedge Clk);
    chk("mid_src", 32'(active_src), 32'h0);
    chk("mid_act", 32'(act_out), 32'h01);
    tick_rise();
    chk("chg_src", 32'(active_src), 32'h2);
    chk("chg_act", 32'(act_out), BLANK_EN ? 32'h0 : 32'h33);
    tick_fall();
    if (BLANK_EN) full_tick();

    // Out-of-range select behaves as no request.
    mode_sel = SEL_W'(3);
    tick_rise();
    chk("oor_act", 32'(act_out), 32'h0);
    chk("oor_x", 32'(x_out), 32'h0);
    chk("oor_y", 32'(y_out), 32'h0);
    tick_fall();

    // Freeze on game over while the source keeps moving.
    src_x = {10'd30, 10'd20, 10'd320};
    mode_sel = SEL_W'(0);
    full_tick();
    if (BLANK_EN) full_tick();
    chk("pre_frz_x", 32'(x_out), 32'd320);
    game_over = 1'b1;
    VGA_VS = 1'b1;
    repeat (2) @(negedge Clk);
    src_x = {10'd30, 10'd20, 10'd5};
    @(negedge Clk);
    chk("frz_x", 32'(x_out), 32'd320);
    tick_fall();
    chk("frz_x_hold", 32'(x_out), 32'd320);
    chk("frz_src", 32'(active_src), 32'h0);
    game_over = 1'b0;
    tick_rise();
    chk("unfrz_x", 32'(x_out), 32'h0);
    chk("unfrz_act", 32'(act_out), 32'h0);
    tick_fall();

    // Re-request during the entry frame.
    mode_sel = SEL_W'(1);
    full_tick();
    mode_sel = SEL_W'(2);
    tick_rise();
    chk("rereq_src", 32'(active_src), 32'h2);
    chk("rereq_sw", 32'(switching), BLANK_EN ? 32'h1 : 32'h0);
    chk("rereq_act", 32'(act_out), BLANK_EN ? 32'h0 : 32'h33);
    tick_fall();

    // Asynchronous reset in the middle of a cycle.
    chk("pre_rst_x", 32'(x_out), 32'd30);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_act", 32'(act_out), 32'h0);
    chk("arst_x", 32'(x_out), 32'h0);
    chk("arst_y", 32'(y_out), 32'h0);
    chk("arst_src", 32'(active_src), 32'h0);
    chk("arst_sw", 32'(switching), 32'h0);

    // VS already high at release gives exactly one tick two cycles later.
    @(negedge Clk);
    VGA_VS = 1'b1; mode_sel = SEL_W'(1);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    chk("rel_src_early", 32'(active_src), 32'h0);
    @(negedge Clk);
    chk("rel_src", 32'(active_src), 32'h1);
    tick_fall();

    // Randomized traffic, checked by the per-cycle model compare.
    vs_cnt = 3;
    for (int c = 0; c < 5000; c++) begin
      @(negedge Clk);
      if (vs_cnt == 0) begin
        VGA_VS = ~VGA_VS;
        vs_cnt = $urandom_range(1, 8);
      end else begin
        vs_cnt--;
      end
      if ($urandom_range(0, 2) == 0) src_act = AW'($urandom);
      if ($urandom_range(0, 2) == 0) src_x = PW'($urandom);
      if ($urandom_range(0, 2) == 0) src_y = PW'($urandom);
      if ($urandom_range(0, 9) == 0) mode_sel = SEL_W'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) mode_en = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 24) == 0) game_over = ~game_over;
      if ($urandom_range(0, 699) == 0) begin
        #2 Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
